// File: rtl/mem_stage_lsu.sv
// Load/store unit in front of the RV32I data memory: one request in flight,
// address/alignment/range check at accept, one-cycle memory access, held response.
module mem_stage_lsu #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_we,
  output logic        rsp_exc,
  output logic [1:0]  rsp_cause
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        op;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  state_t      state, state_nxt;
  req_t        lat;
  logic [31:0] sum;
  logic        misal, legal, fault, exc, accept;
  logic [1:0]  cause;

  // Checks run on the raw sum so the exception response is ready one edge after accept.
  assign sum = req_base + req_offset;

  always_comb begin
    misal = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misal = sum[0];
      2'b10:   misal = |sum[1:0];
      default: misal = 1'b0;
    endcase
    if (req_op) legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    fault = ({2'b00, sum[31:2]} >= MEM_LIMIT) || !legal;
    exc   = misal || fault;
    if (misal)      cause = req_op ? 2'b10 : 2'b01;
    else if (fault) cause = 2'b11;
    else            cause = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_funct3     = '0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
    if (rst) req_ready = 1'b0;
    accept = req_valid & req_ready;
    case (state)
      IDLE: if (accept) state_nxt = exc ? RESP : ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        // A reset landing on the access cycle must not let a store commit.
        if (!rst) begin
          mem_read_en    = ~lat.op;
          mem_write_en   = lat.op;
          mem_address    = lat.addr;
          mem_write_data = lat.data;
          mem_funct3     = lat.funct3;
        end
      end
      RESP: begin
        if (accept)         state_nxt = exc ? RESP : ACCESS;
        else if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      lat       <= '0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_we    <= 1'b0;
      rsp_exc   <= 1'b0;
      rsp_cause <= 2'b00;
    end else if (accept) begin
      lat       <= '{op: req_op, funct3: req_funct3, addr: sum, data: req_store_data};
      rsp_rd    <= req_rd;
      rsp_exc   <= exc;
      rsp_cause <= cause;
      rsp_we    <= 1'b0;
      rsp_data  <= '0;
    end else if (state == ACCESS) begin
      // Load data is captured even for rd=0; only the write enable is suppressed.
      rsp_data <= lat.op ? 32'd0 : mem_read_data;
      rsp_we   <= ~lat.op && (rsp_rd != 5'd0);
    end else if (state == RESP && rsp_ready) begin
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_we    <= 1'b0;
      rsp_exc   <= 1'b0;
      rsp_cause <= 2'b00;
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit sitting directly upstream of the data memory in the RV32I core. It accepts one load/store request from execute over a valid/ready handshake and computes the effective address. It checks alignment and range, drives the data memory's combinational-read / clocked-write port for exactly one cycle, and captures the load result. It then holds that result for writeback until writeback accepts it.

Parameters:
MEM_WORDS, 256, number of 32-bit words in data memory; word index >= MEM_WORDS is an access fault.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  execute presents a request
req_ready  output  1  LSU can accept a request this cycle
req_op  input  1  0 = load, 1 = store
req_funct3  input  3  RV32I LOAD/STORE funct3
req_base  input  32  rs1 value
req_offset  input  32  sign-extended immediate
req_store_data  input  32  rs2 value
req_rd  input  5  load destination register
mem_read_en  output  1  data memory read enable
mem_write_en  output  1  data memory write enable
mem_address  output  32  byte address to memory
mem_write_data  output  32  store data to memory
mem_funct3  output  3  size/sign to memory
mem_read_data  input  32  combinational load result from memory
rsp_valid  output  1  response held for writeback
rsp_ready  input  1  writeback accepts response
rsp_data  output  32  load result (0 for stores/exceptions)
rsp_rd  output  5  destination register
rsp_we  output  1  register write required
rsp_exc  output  1  exception flag
rsp_cause  output  2  01 load misaligned, 10 store misaligned, 11 access fault, 00 none

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset sets state to IDLE. Reset drives all registered outputs and all mem_* outputs to 0, and drives req_ready to 0 during the reset cycle.
- req_ready is 1 in IDLE, and in RESP when rsp_ready=1. It is 0 in ACCESS.
- Accept occurs when req_valid & req_ready at a posedge. On accept, latch:
  - addr = req_base + req_offset, mod 2^32
  - op, funct3, store data, rd
- Exception check at accept, using the unregistered sum. Misaligned has priority over fault.
- Misaligned:
  - Halfword (funct3[1:0]=01) requires addr[0]=0.
  - Word (funct3[1:0]=10) requires addr[1:0]=00.
  - Byte accesses are never misaligned.
- Access fault, cause 11:
  - addr[31:2] >= MEM_WORDS.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
- Clean accept goes to ACCESS. Excepting accept goes straight to RESP with:
  - rsp_exc=1, rsp_cause set
  - rsp_we=0, rsp_data=0
  - no memory access
- ACCESS lasts exactly 1 cycle:
  - mem_address, mem_funct3 and mem_write_data carry the latched values.
  - mem_read_en = ~op.
  - mem_write_en = op & ~rst.
  - Outside ACCESS all mem_* outputs are 0.
  - The store commits at the posedge ending ACCESS.
  - For a load, mem_read_data is captured into rsp_data at that same edge.
  - Next state is RESP.
- RESP:
  - rsp_valid=1, with all rsp_* stable until rsp_ready.
  - Loads: rsp_we = (rd != 0) and rsp_data = captured value. rsp_data is captured even when rd=0.
  - Stores: rsp_we=0, rsp_data=0.
  - On rsp_ready with no new accept, go to IDLE and clear rsp_valid.
  - On rsp_ready with a simultaneous clean accept, go to ACCESS. With a simultaneous excepting accept, stay in RESP with the new response loaded.
- Latency: accept at edge N, ACCESS during cycle N+1, rsp_valid from cycle N+2. Exception path: rsp_valid from cycle N+1. Sustained throughput is 1 request per 2 cycles.
- rsp_ready while not in RESP is ignored. req_* are don't-care when req_valid=0.
- Reset mid-operation:
  - Any state returns to IDLE and the pending response is discarded.
  - In ACCESS, mem_write_en is forced to 0 so no store commits.

Test Plan:
- Reset, then LW with base=0x10, offset=0x4 -> ACCESS drives mem_address=0x14, funct3=010, read_en=1. Memory word 5 = 0xAABBCCDD -> rsp_valid two cycles after accept, rsp_data=0xAABBCCDD, rsp_we=1, rsp_rd as sent.
- SB with data=0x12345678 to addr 0x7, then LBU from 0x7 and LB from 0x7 after storing 0x80 -> results 0x00000078, then 0xFFFFFF80; store responses have rsp_we=0.
- LH at addr 0x3 -> rsp_valid one cycle after accept, rsp_exc=1, cause=01, mem_read_en never asserted. SW at addr 0x2 -> cause=10, mem_write_en never asserted.
- SW to addr 0x400 (word 256) with MEM_WORDS=256 -> cause=11, no write. Load funct3=011 -> cause=11.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_* stable and req_ready=0 throughout. Then rsp_ready=1 together with a new req_valid -> back-to-back accept, next ACCESS the following cycle.
- Assert rst during the ACCESS cycle of SW 0xDEADBEEF to addr 0x20 -> mem_write_en=0, memory word 8 unchanged, next cycle state IDLE, rsp_valid=0.
